// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared core types: fetch FSM states, IF->ID payload, reset PC
package cpu_types_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_SEND,
      S_WAIT_COMMIT
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        valid;
      logic        fetch_err;
   } if_id_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch stage, master of stage_if into decode
module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter bit          CHECK_COMMIT   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        out_pl_valid,
   output logic        out_fetch_err,
   input  logic        commit_valid,
   input  logic [31:0] commit_next_pc,
   output logic [31:0] cur_pc
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   fetch_state_e state_q;
   logic [31:0]  pc_q;
   logic [7:0]   cnt_q;
   if_id_t       pl_q;

   logic pc_aligned;
   assign pc_aligned = (pc_q[1:0] == 2'b00);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         cnt_q   <= 8'd0;
         pl_q    <= '0;
      end else begin
         case (state_q)
            S_REQ: begin
               // A misaligned PC never reaches the bus; it becomes a faulted payload.
               if (!pc_aligned) begin
                  pl_q    <= '{pc: pc_q, inst: 32'h0, valid: 1'b1, fetch_err: 1'b1};
                  state_q <= S_SEND;
               end else if (imem_req_ready) begin
                  cnt_q   <= 8'd0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               // Response is checked first so it beats a simultaneous timeout.
               if (imem_rsp_valid) begin
                  pl_q    <= '{pc: pc_q, inst: imem_rsp_data, valid: 1'b1, fetch_err: imem_rsp_err};
                  state_q <= S_SEND;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  pl_q    <= '{pc: pc_q, inst: 32'h0, valid: 1'b1, fetch_err: 1'b1};
                  state_q <= S_SEND;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_SEND: begin
               if (out_ready) state_q <= S_WAIT_COMMIT;
            end
            S_WAIT_COMMIT: begin
               if (commit_valid) begin
                  pc_q    <= commit_next_pc;
                  state_q <= S_REQ;
               end
            end
            default: state_q <= S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (CHECK_COMMIT && !rst && commit_valid)
         assert (state_q == S_WAIT_COMMIT)
         else $error("commit_valid outside S_WAIT_COMMIT");
   end

   // rst gating keeps every valid low while reset is held.
   assign imem_req_valid = !rst && (state_q == S_REQ) && pc_aligned;
   assign imem_req_addr  = pc_q;
   assign out_valid      = !rst && (state_q == S_SEND);
   assign out_pc         = pl_q.pc;
   assign out_inst       = pl_q.inst;
   assign out_pl_valid   = pl_q.valid;
   assign out_fetch_err  = pl_q.fetch_err;
   assign cur_pc         = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;
   import cpu_types_pkg::*;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid, imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        imem_rsp_err = 1'b0;
   logic        out_valid, out_ready = 1'b0;
   logic [31:0] out_pc, out_inst;
   logic        out_pl_valid, out_fetch_err;
   logic        commit_valid = 1'b0;
   logic [31:0] commit_next_pc = 32'h0;
   logic [31:0] cur_pc;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(255), .CHECK_COMMIT(1'b0)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .out_pl_valid(out_pl_valid), .out_fetch_err(out_fetch_err),
      .commit_valid(commit_valid), .commit_next_pc(commit_next_pc), .cur_pc(cur_pc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst, input logic err);
      exp_t e;
      e.pc = pc; e.inst = inst; e.err = err;
      sb.push_back(e);
   endtask

   task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic err, input int stall, input int lat);
      int n = 0;
      while (!imem_req_valid && n < 20) begin @(negedge clk); n++; end
      chk({tag, "_req_valid"}, imem_req_valid, 1);
      chk({tag, "_req_addr"}, imem_req_addr, addr);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({tag, "_stall_valid"}, imem_req_valid, 1);
         chk({tag, "_stall_addr"}, imem_req_addr, addr);
      end
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      chk({tag, "_req_drop"}, imem_req_valid, 0);
      repeat (lat) @(negedge clk);
      imem_rsp_valid = 1'b1; imem_rsp_data = data; imem_rsp_err = err;
      push_exp(addr, data, err);
      @(negedge clk);
      imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
   endtask

   task automatic expect_out(input string tag, input int hold);
      exp_t e;
      int n = 0;
      while (!out_valid && n < 300) begin @(negedge clk); n++; end
      chk({tag, "_out_valid"}, out_valid, 1);
      chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_pc"}, out_pc, e.pc);
         chk({tag, "_inst"}, out_inst, e.inst);
         chk({tag, "_err"}, out_fetch_err, e.err);
         chk({tag, "_pl_valid"}, out_pl_valid, 1);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_inst"}, out_inst, e.inst);
            chk({tag, "_hold_pc"}, out_pc, e.pc);
            chk({tag, "_hold_noreq"}, imem_req_valid, 0);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_after_fire"}, out_valid, 0);
   endtask

   task automatic commit(input logic [31:0] pc);
      commit_valid = 1'b1; commit_next_pc = pc;
      @(negedge clk);
      commit_valid = 1'b0;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_cur_pc", cur_pc, RST_PC);
      chk("rst_pl_valid", out_pl_valid, 0);
      chk("rst_inst", out_inst, 0);

      // Zero-wait memory: S_REQ, S_WAIT, S_SEND.
      imem_req_ready = 1'b1;
      rst = 1'b0;
      #1;
      chk("c1_req_valid", imem_req_valid, 1);
      chk("c1_req_addr", imem_req_addr, RST_PC);
      @(negedge clk);
      imem_req_ready = 1'b0;
      chk("c2_out_valid", out_valid, 0);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
      push_exp(RST_PC, 32'h0000_0013, 1'b0);
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      chk("c3_out_valid", out_valid, 1);
      expect_out("first", 10);

      commit(32'h8000_0100);
      chk("redir_req_valid", imem_req_valid, 1);
      chk("redir_req_addr", imem_req_addr, 32'h8000_0100);
      do_fetch("buserr", 32'h8000_0100, 32'hDEAD_BEEF, 1'b1, 5, 2);
      expect_out("buserr", 0);

      commit(32'h8000_0102);
      chk("misal_no_req", imem_req_valid, 0);
      chk("misal_cur_pc", cur_pc, 32'h8000_0102);
      push_exp(32'h8000_0102, 32'h0, 1'b1);
      expect_out("misal", 0);

      commit(32'h8000_0200);
      do_fetch("spur", 32'h8000_0200, 32'h00A0_0093, 1'b0, 0, 0);
      commit(32'h9000_0000);
      chk("spur_pc_kept", cur_pc, 32'h8000_0200);
      expect_out("spur", 0);
      repeat (2) begin
         @(negedge clk);
         chk("spur_wait_noreq", imem_req_valid, 0);
         chk("spur_wait_pc", cur_pc, 32'h8000_0200);
      end
      commit(32'h8000_0300);

      chk("to_req_addr", imem_req_addr, 32'h8000_0300);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 300) begin @(negedge clk); n++; end
      chk("to_cycles", n, 255);
      push_exp(32'h8000_0300, 32'h0, 1'b1);
      expect_out("timeout", 0);

      commit(32'h8000_0400);
      chk("rw_req_addr", imem_req_addr, 32'h8000_0400);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rw_rst_req_valid", imem_req_valid, 0);
      chk("rw_rst_out_valid", out_valid, 0);
      rst = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
      #1;
      chk("rw_req_valid", imem_req_valid, 1);
      chk("rw_req_addr_rst", imem_req_addr, RST_PC);
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      chk("rw_late_ignored", out_valid, 0);
      chk("rw_still_req", imem_req_valid, 1);
      do_fetch("post_rst", RST_PC, 32'h0010_0073, 1'b0, 0, 1);
      expect_out("post_rst", 0);

      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
